// File: rtl/mips_fetch_stage.sv
// Instruction-fetch front end: issues word fetches under a credit limit, pairs in-order
// responses with their PCs in a prefetch FIFO, and flushes everything on a core redirect.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   pcq_q       [DEPTH];

    logic [CW:0] credit_used;
    logic        issue;
    logic        rsp;
    logic        drop;
    logic        push;
    logic        pop;

    always_comb begin
        // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
        credit_used = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
        imem_req    = !rst && !redirect_valid && (credit_used < CREDIT);
        imem_addr   = fetch_pc_q;
        inst_valid  = !rst && (fifo_cnt_q != '0);
        inst        = inst_valid ? fifo_inst_q[fifo_rd_q] : '0;
        inst_pc     = inst_valid ? fifo_pc_q[fifo_rd_q] : '0;
        issue       = imem_req && imem_gnt;
        rsp         = imem_rvalid && (out_cnt_q != '0);
        drop        = rsp && (redirect_valid || (discard_q != '0));
        push        = rsp && !drop;
        pop         = inst_valid && inst_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        discard_d  = discard_q;
        // Every response retires its PC-queue entry, dropped or not, to keep pairing aligned.
        pcq_wr_d   = pcq_wr_q + AW'(issue);
        pcq_rd_d   = pcq_rd_q + AW'(rsp);
        out_cnt_d  = out_cnt_q + CW'(issue) - CW'(rsp);
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            discard_d  = out_cnt_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            fifo_wr_d  = fifo_wr_q + AW'(push);
            fifo_rd_d  = fifo_rd_q + AW'(pop);
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            discard_d  = discard_q - CW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            discard_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            discard_q  <= discard_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (!rst && push) begin
            fifo_inst_q[fifo_wr_q] <= imem_rdata;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
    end

    // A response with nothing outstanding is ignored by the datapath but flagged here.
    property p_rvalid_tracked;
        @(posedge clk) disable iff (rst) imem_rvalid |-> (out_cnt_q != '0);
    endproperty
    a_rvalid_tracked: assert property (p_rvalid_tracked);

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: fixed-latency memory, queue-based stream model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mips_fetch_stage;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    mips_fetch_stage #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd7 + 32'h2408_0001;
    endfunction

    // Memory: in-order, fixed latency, reset along with the DUT.
    typedef struct packed { logic [31:0] addr; int due; } mr_t;
    mr_t memq[$];

    always @(posedge clk) begin
        #2;
        if (!rst && memq.size() != 0 && memq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            memq.delete();
        end else begin
            if (imem_rvalid) void'(memq.pop_front());
            if (imem_req && imem_gnt) memq.push_back('{addr: imem_addr, due: cyc + lat});
        end
    end

    // Stream model: in-flight fetches (tagged stale on redirect) and buffered instructions.
    typedef struct packed { logic [31:0] pc; logic stale; } fl_t;
    typedef struct packed { logic [31:0] word; logic [31:0] pc; } fe_t;
    fl_t         mq[$];
    fe_t         fq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] pop_pcs[$];
    int          pop_cyc[$];
    logic [31:0] issue_addrs[$];
    int          drops = 0;

    always @(negedge clk) begin : model
        logic er;
        logic ev;
        fl_t  e;
        if (rst) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", inst_valid, 1'b0);
            chk("rst_inst", inst, '0);
            chk("rst_inst_pc", inst_pc, '0);
            mq.delete();
            fq.delete();
            m_pc = RESET_PC;
        end else begin
            er = !redirect_valid && (fq.size() + mq.size() < DEPTH);
            ev = fq.size() != 0;
            chk("req", imem_req, er);
            if (er) chk("addr", imem_addr, m_pc);
            chk("valid", inst_valid, ev);
            if (ev) begin
                chk("inst", inst, fq[0].word);
                chk("inst_pc", inst_pc, fq[0].pc);
            end
            if (ev && inst_ready) begin
                pop_pcs.push_back(fq[0].pc);
                pop_cyc.push_back(cyc);
                void'(fq.pop_front());
            end
            if (imem_rvalid) begin
                if (mq.size() == 0) begin
                    chk("rvalid_tracked", 32'd0, 32'd1);
                end else begin
                    e = mq.pop_front();
                    if (e.stale || redirect_valid) drops++;
                    else fq.push_back('{word: imem_rdata, pc: e.pc});
                end
            end
            if (er && imem_gnt) begin
                mq.push_back('{pc: m_pc, stale: 1'b0});
                issue_addrs.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                fq.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                m_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        pop_pcs.delete();
        pop_cyc.delete();
        issue_addrs.delete();
        drops = 0;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        redirect_valid = 1'b0;
        lat = l;
        tick();
        tick();
        rst = 1'b0;
        clr();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        // Reset then stream
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        do_reset(1);
        @(negedge clk);
        chk("t1_valid_c0", inst_valid, 1'b0);
        chk("t1_req_c0", imem_req, 1'b1);
        chk("t1_addr_c0", imem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("t1_valid_c1", inst_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_valid_c2", inst_valid, 1'b1);
        chk("t1_pc_c2", inst_pc, 32'h0);
        chk("t1_inst_c2", inst, 32'h2408_0001);
        repeat (5) tick();
        chk("t1_pop_count", 32'(pop_pcs.size() >= 4), 32'd1);
        if (pop_pcs.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_pop_pc", pop_pcs[i], 32'(4 * i));
                chk("t1_pop_cycle", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
            end
        end

        // Backpressure
        inst_ready = 1'b0;
        do_reset(1);
        repeat (10) tick();
        @(negedge clk);
        chk("t2_issued", 32'(issue_addrs.size()), 32'd4);
        chk("t2_req_off", imem_req, 1'b0);
        chk("t2_head_pc", inst_pc, 32'h0);
        tick();
        inst_ready = 1'b1;
        repeat (8) tick();
        chk("t2_pop_count", 32'(pop_pcs.size() >= 4), 32'd1);
        if (pop_pcs.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t2_pop_pc", pop_pcs[i], 32'(4 * i));
        end
        chk("t2_resume_count", 32'(issue_addrs.size() >= 5), 32'd1);
        if (issue_addrs.size() >= 5) chk("t2_resume_addr", issue_addrs[4], 32'h10);

        // Redirect with two in flight, latency 3
        do_reset(3);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("t3_req_redirect", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        clr();
        @(negedge clk);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_req", imem_req, 1'b1);
        repeat (8) tick();
        chk("t3_drops", 32'(drops), 32'd2);
        chk("t3_pop_count", 32'(pop_pcs.size() >= 2), 32'd1);
        if (pop_pcs.size() >= 2) begin
            chk("t3_first_pc", pop_pcs[0], 32'h100);
            chk("t3_second_pc", pop_pcs[1], 32'h104);
        end

        // Redirect coincident with response and pop
        do_reset(1);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("t4_valid", inst_valid, 1'b1);
        chk("t4_pc", inst_pc, 32'h4);
        chk("t4_rvalid", imem_rvalid, 1'b1);
        chk("t4_req", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed", inst_valid, 1'b0);
        repeat (5) tick();
        chk("t4_drops", 32'(drops), 32'd1);
        chk("t4_pop_count", 32'(pop_pcs.size() >= 3), 32'd1);
        if (pop_pcs.size() >= 3) begin
            chk("t4_pop0", pop_pcs[0], 32'h0);
            chk("t4_pop1", pop_pcs[1], 32'h4);
            chk("t4_pop2", pop_pcs[2], 32'h200);
        end

        // Wrap at top of address space
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        issue_addrs.delete();
        tick();
        redirect_valid = 1'b0;
        pop_pcs.delete();
        repeat (6) tick();
        chk("t5_issue_count", 32'(issue_addrs.size() >= 3), 32'd1);
        if (issue_addrs.size() >= 3) begin
            chk("t5_issue0", issue_addrs[0], 32'hFFFF_FFFC);
            chk("t5_issue1", issue_addrs[1], 32'h0);
            chk("t5_issue2", issue_addrs[2], 32'h4);
        end
        chk("t5_pop_count", 32'(pop_pcs.size() >= 2), 32'd1);
        if (pop_pcs.size() >= 2) begin
            chk("t5_pop0", pop_pcs[0], 32'hFFFF_FFFC);
            chk("t5_pop1", pop_pcs[1], 32'h0);
        end

        // Reset with three outstanding, then a grant stall at RESET_PC
        do_reset(3);
        tick();
        tick();
        tick();
        rst = 1'b1;
        lat = 1;
        @(negedge clk);
        chk("t6_req_rst0", imem_req, 1'b0);
        chk("t6_valid_rst0", inst_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("t6_req_rst1", imem_req, 1'b0);
        chk("t6_valid_rst1", inst_valid, 1'b0);
        chk("t6_pc_rst1", inst_pc, 32'h0);
        tick();
        rst = 1'b0;
        imem_gnt = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_stall_req", imem_req, 1'b1);
            chk("t6_stall_addr", imem_addr, RESET_PC);
            tick();
        end
        imem_gnt = 1'b1;
        repeat (4) tick();
        chk("t6_pop_count", 32'(pop_pcs.size() >= 2), 32'd1);
        if (pop_pcs.size() >= 2) begin
            chk("t6_pop0", pop_pcs[0], 32'h0);
            chk("t6_pop1", pop_pcs[1], 32'h4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch front end that feeds the single-cycle MIPS core. It owns the fetch PC and issues word requests to instruction memory over a request/grant + response-valid interface. It buffers returned instructions in a small in-order prefetch FIFO and hands them to the core over a valid/ready handshake. Branch/jump redirects from the core flush buffered and in-flight fetches and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (bits [1:0] must be 0)
DEPTH, 4, prefetch FIFO entries; also the credit limit on buffered plus in-flight fetches (power of two, at least 2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  32  byte address of the requested word, always word-aligned
imem_gnt  in  1  memory accepts the request this cycle (req & gnt = issued)
imem_rvalid  in  1  read data valid; responses arrive in issue order
imem_rdata  in  32  instruction word
inst_valid  out  1  FIFO head holds a valid instruction
inst  out  32  instruction at FIFO head
inst_pc  out  32  byte address of inst
inst_ready  in  1  core consumes head (valid & ready = pop)
redirect_valid  in  1  core-computed branch/jump taken
redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (rst=1 at an edge), regardless of in-flight activity:
  - fetch_pc = RESET_PC.
  - FIFO count, outstanding count and discard count all 0.
  - inst_valid=0, inst=0, inst_pc=0, imem_req=0 for every cycle rst is high.
  - Responses arriving after reset that belong to pre-reset requests are not tracked. The memory is reset with the same rst.
- Credit rule: imem_req=1 when rst=0, redirect_valid=0 and (fifo_count + outstanding) < DEPTH. imem_addr = fetch_pc, combinational from registers.
- Issue: on req & gnt:
  - outstanding +1;
  - fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC goes to 0).
  - The issued PC is pushed to an internal PC queue (DEPTH entries) so it pairs with its response.
  - If req is high without gnt, address is held. Req may drop only when credit is exhausted or a redirect occurs.
- Response: on imem_rvalid:
  - If discard_count > 0: drop the word, discard_count -1, outstanding -1.
  - Otherwise write {imem_rdata, matching PC} into the FIFO and decrement outstanding. The credit rule guarantees space, so there is no overflow path.
- Output: inst_valid=1 whenever fifo_count > 0. inst and inst_pc are the head entry.
  - No bypass: a word written at edge N is visible after edge N.
  - Minimum latency with a 1-cycle memory: req/gnt in cycle 0, rvalid in cycle 1, inst_valid in cycle 2.
  - Sustained throughput is 1 instruction/cycle when DEPTH≥3 and gnt/ready are held high.
- Pop: valid & ready frees the head entry. Simultaneous push and pop leaves fifo_count unchanged.
- Redirect (redirect_valid=1 at edge):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO emptied, so inst_valid=0 the next cycle.
  - discard_count = outstanding after this edge's updates. A response arriving the same cycle is dropped; it belongs to the old stream.
  - imem_req is forced 0 in the redirect cycle, so no grant can coincide with it.
  - A pop handshake completing in the redirect cycle counts as consumed.
  - Back-to-back redirects: the last one wins, and discard_count accumulates correctly.
- Priority at an edge: rst > redirect > normal issue/response/pop.
- Illegal: imem_rvalid with outstanding=0 is ignored; it triggers an assertion in simulation.

Test Plan:
- Reset then stream: RESET_PC=0, gnt=1, 1-cycle rvalid, inst_ready=1.
  - inst_valid first high 2 cycles after rst falls.
  - inst_pc sequence 0,4,8,12 on consecutive cycles, each inst equal to the memory word.
- Backpressure: inst_ready=0 for 10 cycles.
  - Exactly 4 requests issue, then imem_req=0.
  - On ready=1, PCs 0,4,8,12 pop in order and requests resume at 16.
- Redirect with 2 in flight: latency 3, redirect_pc=32'h0000_0103.
  - The 2 old responses are dropped.
  - Next imem_addr=32'h100, and the first inst_pc after redirect is 32'h100.
- Redirect coincident with rvalid and pop: the popped instruction is consumed, the arriving word is discarded, and inst_valid=0 next cycle.
- Wrap and reset mid-operation:
  - redirect_pc=32'hFFFF_FFFC gives fetch sequence FFFF_FFFC, 0000_0000.
  - Asserting rst with 3 outstanding gives imem_req=0 and inst_valid=0 during reset, then fetch from RESET_PC.
